// File: rtl/ldq_entry_split.sv
// Load-queue entry: holds one load from allocation to completion, splitting
// line-crossing accesses into two mempipe requests, with age nukes and recycle backoff.
module ldq_entry_split #(
  parameter int unsigned VA_W            = 64,
  parameter int unsigned ROB_W           = 7,
  parameter int unsigned PDST_W          = 7,
  parameter int unsigned LDQ_W           = 4,
  parameter int unsigned STQ_N           = 8,
  parameter int unsigned LINE_BYTES      = 64,
  parameter int unsigned MAX_BACKOFF     = 7,
  parameter int unsigned BLOCK_ON_ELDERS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LDQ_W-1:0]  id,
  input  logic              nuke_valid,
  input  logic              nuke_all,
  input  logic [ROB_W-1:0]  nuke_robid,
  input  logic [STQ_N-1:0]  stq_valid,
  input  logic              alloc,
  input  logic [ROB_W-1:0]  alloc_robid,
  input  logic [1:0]        alloc_size,
  input  logic              iss_valid,
  input  logic [LDQ_W-1:0]  iss_ldqid,
  input  logic [VA_W-1:0]   iss_src1,
  input  logic [VA_W-1:0]   iss_src2,
  input  logic [PDST_W-1:0] iss_pdst,
  output logic              e_valid,
  output logic [ROB_W-1:0]  e_robid,
  output logic              req,
  output logic [VA_W-1:0]   req_addr,
  output logic [3:0]        req_bytes,
  output logic              req_half,
  output logic [ROB_W-1:0]  req_robid,
  output logic [PDST_W-1:0] req_pdst,
  output logic [LDQ_W-1:0]  req_id,
  input  logic              gnt,
  input  logic              rsp_valid,
  input  logic [LDQ_W-1:0]  rsp_id,
  input  logic              rsp_half,
  input  logic              rsp_complete,
  input  logic              rsp_recycle
);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned CW    = OFF_W + 2;
  localparam int unsigned RC_W  = (MAX_BACKOFF < 1) ? 1 : $clog2(MAX_BACKOFF + 1);

  typedef enum logic [2:0] {IDLE, PDG_ISS, REQ, PDG_PIPE, BACKOFF} state_e;

  state_e             state_q, state_d;
  logic [ROB_W-1:0]   robid_q, robid_d;
  logic [1:0]         size_q, size_d;
  logic [PDST_W-1:0]  pdst_q, pdst_d;
  logic [VA_W-1:0]    addr_q, addr_d;
  logic [3:0]         bytes_q, bytes_d;
  logic               half_q, half_d;
  logic               split_q, split_d;
  logic [RC_W-1:0]    rc_q, rc_d, bo_q, bo_d, rc_inc;
  logic [STQ_N-1:0]   elders_q, elders_d;

  logic [VA_W-1:0]    iss_sum, next_line;
  logic [CW-1:0]      off_ext, n_ext, line_c;
  logic [3:0]         n_bytes, head_bytes;
  logic               iss_split, blocked, nuked, rsp_hit;

  assign iss_sum    = iss_src1 + iss_src2;
  assign n_bytes    = 4'd1 << size_q;
  assign off_ext    = CW'(iss_sum[OFF_W-1:0]);
  assign n_ext      = CW'(n_bytes);
  assign line_c     = CW'(LINE_BYTES);
  assign iss_split  = (off_ext + n_ext) > line_c;
  assign head_bytes = 4'(line_c - off_ext);
  assign next_line  = {addr_q[VA_W-1:OFF_W], {OFF_W{1'b0}}} + VA_W'(LINE_BYTES);
  assign rc_inc     = (rc_q >= RC_W'(MAX_BACKOFF)) ? RC_W'(MAX_BACKOFF) : rc_q + RC_W'(1);

  assign blocked = (BLOCK_ON_ELDERS != 0) && (|elders_q);
  assign rsp_hit = rsp_valid && (rsp_id == id) && (rsp_half == half_q);
  // Entry is the nuke robid or younger when the modular distance is in the lower half.
  assign nuked   = nuke_valid && (state_q != IDLE) &&
                   (nuke_all || (ROB_W'(robid_q - nuke_robid) < ROB_W'(1 << (ROB_W - 1))));

  assign e_valid   = (state_q != IDLE);
  assign e_robid   = robid_q;
  assign req       = (state_q == REQ) && !blocked;
  assign req_addr  = addr_q;
  assign req_bytes = bytes_q;
  assign req_half  = half_q;
  assign req_robid = robid_q;
  assign req_pdst  = pdst_q;
  assign req_id    = id;

  always_comb begin
    state_d  = state_q;
    robid_d  = robid_q;
    size_d   = size_q;
    pdst_d   = pdst_q;
    addr_d   = addr_q;
    bytes_d  = bytes_q;
    half_d   = half_q;
    split_d  = split_q;
    rc_d     = rc_q;
    bo_d     = bo_q;
    elders_d = elders_q & stq_valid;
    case (state_q)
      IDLE: begin
        if (alloc && !nuke_valid) begin
          state_d  = PDG_ISS;
          robid_d  = alloc_robid;
          size_d   = alloc_size;
          rc_d     = '0;
          half_d   = 1'b0;
          elders_d = stq_valid;
        end
      end
      PDG_ISS: begin
        if (iss_valid && (iss_ldqid == id)) begin
          state_d = REQ;
          addr_d  = iss_sum;
          pdst_d  = iss_pdst;
          split_d = iss_split;
          bytes_d = iss_split ? head_bytes : n_bytes;
        end
      end
      REQ: begin
        if (req && gnt) state_d = PDG_PIPE;
      end
      PDG_PIPE: begin
        if (rsp_hit) begin
          if (rsp_complete) begin
            // Head piece held LINE_BYTES-off bytes, so the tail is n minus that.
            if (split_q && !half_q) begin
              state_d = REQ;
              half_d  = 1'b1;
              addr_d  = next_line;
              bytes_d = n_bytes - bytes_q;
            end else begin
              state_d = IDLE;
            end
          end else if (rsp_recycle) begin
            state_d = BACKOFF;
            rc_d    = rc_inc;
            bo_d    = rc_inc;
          end
        end
      end
      BACKOFF: begin
        bo_d = bo_q - RC_W'(1);
        if (bo_q == RC_W'(1)) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (nuked) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      robid_q  <= '0;
      size_q   <= '0;
      pdst_q   <= '0;
      addr_q   <= '0;
      bytes_q  <= '0;
      half_q   <= 1'b0;
      split_q  <= 1'b0;
      rc_q     <= '0;
      bo_q     <= '0;
      elders_q <= '0;
    end else begin
      state_q  <= state_d;
      robid_q  <= robid_d;
      size_q   <= size_d;
      pdst_q   <= pdst_d;
      addr_q   <= addr_d;
      bytes_q  <= bytes_d;
      half_q   <= half_d;
      split_q  <= split_d;
      rc_q     <= rc_d;
      bo_q     <= bo_d;
      elders_q <= elders_d;
    end
  end

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_alloc_busy: assert (!(alloc && e_valid)) else $error("alloc while entry valid");
      a_iss_state:  assert (!(iss_valid && (iss_ldqid == id) && (state_q != PDG_ISS)))
        else $error("issue outside PDG_ISS");
      a_size:       assert (!(alloc && (alloc_size > 2'd3))) else $error("alloc_size out of range");
    end
  end
`endif
endmodule

// File: tb/tb_ldq_entry_split.sv
// Scoreboard bench for ldq_entry_split: directed load scenarios on the default entry,
// plus a MAX_BACKOFF=2 / non-blocking instance driven by the same stimulus.
module tb_ldq_entry_split;
  localparam int unsigned VA_W = 64, ROB_W = 7, PDST_W = 7, LDQ_W = 4, STQ_N = 8;
  localparam logic [LDQ_W-1:0] MY_ID = 4'd3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              nuke_valid = 0, nuke_all = 0;
  logic [ROB_W-1:0]  nuke_robid = '0;
  logic [STQ_N-1:0]  stq_valid = '0;
  logic              alloc = 0;
  logic [ROB_W-1:0]  alloc_robid = '0;
  logic [1:0]        alloc_size = '0;
  logic              iss_valid = 0;
  logic [LDQ_W-1:0]  iss_ldqid = '0;
  logic [VA_W-1:0]   iss_src1 = '0, iss_src2 = '0;
  logic [PDST_W-1:0] iss_pdst = '0;
  logic              gnt = 0, rsp_valid = 0, rsp_half = 0, rsp_complete = 0, rsp_recycle = 0;
  logic [LDQ_W-1:0]  rsp_id = '0;

  logic              e_valid, req, req_half;
  logic [ROB_W-1:0]  e_robid, req_robid;
  logic [VA_W-1:0]   req_addr;
  logic [3:0]        req_bytes;
  logic [PDST_W-1:0] req_pdst;
  logic [LDQ_W-1:0]  req_id;

  logic              e_valid2, req2, req_half2;
  logic [ROB_W-1:0]  e_robid2, req_robid2;
  logic [VA_W-1:0]   req_addr2;
  logic [3:0]        req_bytes2;
  logic [PDST_W-1:0] req_pdst2;
  logic [LDQ_W-1:0]  req_id2;

  ldq_entry_split dut (
    .clk(clk), .reset(reset), .id(MY_ID),
    .nuke_valid(nuke_valid), .nuke_all(nuke_all), .nuke_robid(nuke_robid),
    .stq_valid(stq_valid), .alloc(alloc), .alloc_robid(alloc_robid), .alloc_size(alloc_size),
    .iss_valid(iss_valid), .iss_ldqid(iss_ldqid), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_pdst(iss_pdst), .e_valid(e_valid), .e_robid(e_robid), .req(req), .req_addr(req_addr),
    .req_bytes(req_bytes), .req_half(req_half), .req_robid(req_robid), .req_pdst(req_pdst),
    .req_id(req_id), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_half(rsp_half),
    .rsp_complete(rsp_complete), .rsp_recycle(rsp_recycle)
  );

  ldq_entry_split #(.MAX_BACKOFF(2), .BLOCK_ON_ELDERS(0)) dut2 (
    .clk(clk), .reset(reset), .id(MY_ID),
    .nuke_valid(nuke_valid), .nuke_all(nuke_all), .nuke_robid(nuke_robid),
    .stq_valid(stq_valid), .alloc(alloc), .alloc_robid(alloc_robid), .alloc_size(alloc_size),
    .iss_valid(iss_valid), .iss_ldqid(iss_ldqid), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_pdst(iss_pdst), .e_valid(e_valid2), .e_robid(e_robid2), .req(req2), .req_addr(req_addr2),
    .req_bytes(req_bytes2), .req_half(req_half2), .req_robid(req_robid2), .req_pdst(req_pdst2),
    .req_id(req_id2), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_half(rsp_half),
    .rsp_complete(rsp_complete), .rsp_recycle(rsp_recycle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VA_W-1:0]   addr;
    logic [3:0]        bytes;
    logic              half;
    logic [ROB_W-1:0]  robid;
    logic [PDST_W-1:0] pdst;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: every granted request is matched against the oldest expected request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && req && gnt) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_req: got addr=0x%0h bytes=%0d half=%0d, required no request",
                 req_addr, req_bytes, req_half);
      end else begin
        e = sb_q.pop_front();
        if (req_addr !== e.addr || req_bytes !== e.bytes || req_half !== e.half ||
            req_robid !== e.robid || req_pdst !== e.pdst || req_id !== MY_ID) begin
          miscompares++;
          $display("FAIL req_contents: got addr=0x%0h bytes=%0d half=%0d robid=0x%0h pdst=0x%0h id=%0d, required addr=0x%0h bytes=%0d half=%0d robid=0x%0h pdst=0x%0h id=%0d",
                   req_addr, req_bytes, req_half, req_robid, req_pdst, req_id,
                   e.addr, e.bytes, e.half, e.robid, e.pdst, MY_ID);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_e_valid"},   64'(e_valid),   64'd0);
    check({tag, "_req"},       64'(req),       64'd0);
    check({tag, "_req_addr"},  req_addr,       64'd0);
    check({tag, "_req_bytes"}, 64'(req_bytes), 64'd0);
    check({tag, "_req_half"},  64'(req_half),  64'd0);
    check({tag, "_req_robid"}, 64'(req_robid), 64'd0);
    check({tag, "_req_pdst"},  64'(req_pdst),  64'd0);
    check({tag, "_e_robid"},   64'(e_robid),   64'd0);
    check({tag, "_req_id"},    64'(req_id),    64'(MY_ID));
    check({tag, "_e_valid2"},  64'(e_valid2),  64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_t(input logic [ROB_W-1:0] rid, input logic [1:0] sz);
    alloc = 1'b1; alloc_robid = rid; alloc_size = sz;
    tick();
    alloc = 1'b0;
  endtask

  task automatic issue_t(input logic [VA_W-1:0] a, input logic [VA_W-1:0] b,
                         input logic [PDST_W-1:0] pd);
    iss_valid = 1'b1; iss_ldqid = MY_ID; iss_src1 = a; iss_src2 = b; iss_pdst = pd;
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic grant_t();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
  endtask

  task automatic rsp_t(input logic [LDQ_W-1:0] rid, input logic h, input logic c, input logic r);
    rsp_valid = 1'b1; rsp_id = rid; rsp_half = h; rsp_complete = c; rsp_recycle = r;
    tick();
    rsp_valid = 1'b0; rsp_complete = 1'b0; rsp_recycle = 1'b0;
  endtask

  task automatic nuke_t(input logic all, input logic [ROB_W-1:0] rid);
    nuke_valid = 1'b1; nuke_all = all; nuke_robid = rid;
    tick();
    nuke_valid = 1'b0; nuke_all = 1'b0;
  endtask

  // Cycles from the recycle response until each entry raises req (-1 if never).
  task automatic wait_req(output int n, output int n2);
    n = -1;
    n2 = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (n2 < 0 && req2) n2 = c;
      if (n < 0 && req) n = c;
      if (n >= 0 && n2 >= 0) break;
    end
  endtask

  initial begin
    exp_t e;
    int n, n2;

    // Reset state
    do_reset();
    check_reset_vals("reset");

    // Aligned 8-byte load
    alloc_t(7'h05, 2'd3);
    check("alloc_e_valid", 64'(e_valid), 64'd1);
    check("alloc_e_robid", 64'(e_robid), 64'h05);
    check("alloc_no_req", 64'(req), 64'd0);
    sb_q.push_back('{addr: 64'h1008, bytes: 4'd8, half: 1'b0, robid: 7'h05, pdst: 7'h11});
    issue_t(64'h1000, 64'h8, 7'h11);
    check("aligned_req_rise", 64'(req), 64'd1);
    grant_t();
    check("aligned_req_drop", 64'(req), 64'd0);
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    check("aligned_done", 64'(e_valid), 64'd0);

    // Ends exactly on the line boundary: not split; complete beats recycle
    alloc_t(7'h06, 2'd2);
    sb_q.push_back('{addr: 64'h203C, bytes: 4'd4, half: 1'b0, robid: 7'h06, pdst: 7'h12});
    issue_t(64'h2000, 64'h3C, 7'h12);
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b1);
    check("boundary_single_piece_done", 64'(e_valid), 64'd0);

    // Line-crossing 8-byte load at 0x103C
    alloc_t(7'h07, 2'd3);
    sb_q.push_back('{addr: 64'h103C, bytes: 4'd4, half: 1'b0, robid: 7'h07, pdst: 7'h13});
    issue_t(64'h1030, 64'hC, 7'h13);
    check("split_req_rise", 64'(req), 64'd1);
    tick();
    tick();
    check("split_req_held", 64'(req), 64'd1);
    check("split_addr_held", req_addr, 64'h103C);
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    check("split_half1_req", 64'(req), 64'd1);
    check("split_half1_flag", 64'(req_half), 64'd1);
    sb_q.push_back('{addr: 64'h1040, bytes: 4'd4, half: 1'b1, robid: 7'h07, pdst: 7'h13});
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    check("stale_half0_ignored", 64'(e_valid), 64'd1);
    rsp_t(4'd5, 1'b1, 1'b1, 1'b0);
    check("other_id_ignored", 64'(e_valid), 64'd1);
    rsp_t(MY_ID, 1'b1, 1'b1, 1'b0);
    check("split_done", 64'(e_valid), 64'd0);

    // 2-byte load at last byte of a line; tail piece recycled once
    alloc_t(7'h08, 2'd1);
    sb_q.push_back('{addr: 64'h7F, bytes: 4'd1, half: 1'b0, robid: 7'h08, pdst: 7'h16});
    sb_q.push_back('{addr: 64'h80, bytes: 4'd1, half: 1'b1, robid: 7'h08, pdst: 7'h16});
    issue_t(64'h7F, 64'h0, 7'h16);
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    grant_t();
    rsp_t(MY_ID, 1'b1, 1'b0, 1'b1);
    wait_req(n, n2);
    check("tail_recycle_wait", 64'(n), 64'd1);
    check("tail_retry_half", 64'(req_half), 64'd1);
    sb_q.push_back('{addr: 64'h80, bytes: 4'd1, half: 1'b1, robid: 7'h08, pdst: 7'h16});
    grant_t();
    rsp_t(MY_ID, 1'b1, 1'b1, 1'b0);
    check("tail_done", 64'(e_valid), 64'd0);

    // Linear backoff: 1,2,3 cycles (2nd instance saturates at 2)
    e = '{addr: 64'h3000, bytes: 4'd8, half: 1'b0, robid: 7'h09, pdst: 7'h14};
    alloc_t(7'h09, 2'd3);
    sb_q.push_back(e);
    issue_t(64'h3000, 64'h0, 7'h14);
    grant_t();
    for (int k = 1; k <= 3; k++) begin
      rsp_t(MY_ID, 1'b0, 1'b0, 1'b1);
      check($sformatf("backoff%0d_req_low", k), 64'(req), 64'd0);
      wait_req(n, n2);
      check($sformatf("backoff%0d_cycles", k), 64'(n), 64'(k));
      check($sformatf("backoff%0d_cycles_max2", k), 64'(n2), 64'((k == 3) ? 2 : k));
      sb_q.push_back(e);
      grant_t();
    end
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    check("backoff_done", 64'(e_valid), 64'd0);
    e.robid = 7'h0A;
    alloc_t(7'h0A, 2'd3);
    sb_q.push_back(e);
    issue_t(64'h3000, 64'h0, 7'h14);
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b0, 1'b1);
    wait_req(n, n2);
    check("realloc_backoff_restart", 64'(n), 64'd1);
    check("realloc_backoff_restart_max2", 64'(n2), 64'd1);
    sb_q.push_back(e);
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);

    // Elder-store blocking: bits 0 and 2 elder, bit 3 arrives later
    stq_valid = 8'h05;
    alloc_t(7'h10, 2'd3);
    stq_valid = 8'h0D;
    issue_t(64'h4000, 64'h10, 7'h15);
    check("elder_blocked", 64'(req), 64'd0);
    check("elder_noblock_inst", 64'(req2), 64'd1);
    stq_valid = 8'h0C;
    tick();
    check("elder_still_blocked", 64'(req), 64'd0);
    stq_valid = 8'h08;
    tick();
    check("elder_released", 64'(req), 64'd1);
    sb_q.push_back('{addr: 64'h4010, bytes: 4'd8, half: 1'b0, robid: 7'h10, pdst: 7'h15});
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    stq_valid = 8'h00;
    check("elder_done", 64'(e_valid), 64'd0);

    // Age-qualified nukes
    alloc_t(7'h42, 2'd3);
    nuke_t(1'b0, 7'h40);
    check("nuke_older_flushes", 64'(e_valid), 64'd0);
    alloc_t(7'h42, 2'd3);
    nuke_t(1'b0, 7'h43);
    check("nuke_younger_survives", 64'(e_valid), 64'd1);
    check("nuke_survivor_robid", 64'(e_robid), 64'h42);
    nuke_t(1'b1, 7'h43);
    check("nuke_all_pdg_iss", 64'(e_valid), 64'd0);
    alloc_t(7'h02, 2'd3);
    nuke_t(1'b0, 7'h7E);
    check("nuke_wrap_flushes", 64'(e_valid), 64'd0);

    alloc_t(7'h42, 2'd3);
    issue_t(64'h5000, 64'h0, 7'h17);
    nuke_t(1'b1, 7'h43);
    check("nuke_all_req_state", 64'(e_valid), 64'd0);
    check("nuke_all_req_drop", 64'(req), 64'd0);

    e = '{addr: 64'h5000, bytes: 4'd8, half: 1'b0, robid: 7'h42, pdst: 7'h17};
    alloc_t(7'h42, 2'd3);
    sb_q.push_back(e);
    issue_t(64'h5000, 64'h0, 7'h17);
    grant_t();
    nuke_t(1'b1, 7'h43);
    check("nuke_all_pdg_pipe", 64'(e_valid), 64'd0);

    alloc_t(7'h42, 2'd3);
    sb_q.push_back(e);
    issue_t(64'h5000, 64'h0, 7'h17);
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b0, 1'b1);
    check("backoff_entered", 64'(e_valid), 64'd1);
    nuke_t(1'b1, 7'h43);
    check("nuke_all_backoff", 64'(e_valid), 64'd0);
    tick();
    check("nuke_backoff_no_req", 64'(req), 64'd0);

    alloc_t(7'h42, 2'd3);
    sb_q.push_back('{addr: 64'h103C, bytes: 4'd4, half: 1'b0, robid: 7'h42, pdst: 7'h18});
    issue_t(64'h103C, 64'h0, 7'h18);
    grant_t();
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    check("nuke_half1_setup", 64'(req_half), 64'd1);
    nuke_t(1'b1, 7'h43);
    check("nuke_all_half1_req", 64'(e_valid), 64'd0);
    check("nuke_half1_req_drop", 64'(req), 64'd0);

    nuke_valid = 1'b1; nuke_robid = 7'h00;
    alloc_t(7'h11, 2'd0);
    nuke_valid = 1'b0;
    check("alloc_during_nuke_ignored", 64'(e_valid), 64'd0);

    // Reset in PDG_PIPE with a same-cycle completion
    alloc_t(7'h33, 2'd3);
    sb_q.push_back('{addr: 64'h6000, bytes: 4'd8, half: 1'b0, robid: 7'h33, pdst: 7'h19});
    issue_t(64'h6000, 64'h0, 7'h19);
    grant_t();
    reset = 1'b1;
    rsp_t(MY_ID, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    check_reset_vals("midreset");
    tick();
    tick();
    tick();
    check("midreset_no_req", 64'(req), 64'd0);
    check("midreset_idle", 64'(e_valid), 64'd0);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
